// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I hazard controller: forwarding selects, the
// memory-wait FSM states and the shadow-pipeline slot record.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic       reg_write;
        logic       load;
        logic       mem_op;
    } hz_slot_t;

    localparam logic [4:0] X0          = 5'd0;
    localparam hz_slot_t   SLOT_BUBBLE = '0;

    // A load sitting in MEM has no data yet, so only WB may supply it.
    function automatic fwd_sel_t fwd_select(input logic       use_src,
                                            input logic [4:0] src,
                                            input hz_slot_t   mem,
                                            input hz_slot_t   wb);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (use_src && src != X0) begin
            if (mem.reg_write && !mem.load && mem.rd == src) begin
                sel = FWD_MEM;
            end else if (wb.reg_write && wb.rd == src) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hz_shadow_pipe.sv
// Three-slot shadow of the EX/MEM/WB register metadata; advances on
// i_advance, inserting a bubble into EX when i_bubble is set.
module hz_shadow_pipe
    import pipeline_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_advance,
    input  logic     i_bubble,
    input  hz_slot_t i_id_slot,
    output hz_slot_t o_ex,
    output hz_slot_t o_mem,
    output hz_slot_t o_wb
);

    hz_slot_t r_ex;
    hz_slot_t r_mem;
    hz_slot_t r_wb;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex  <= SLOT_BUBBLE;
            r_mem <= SLOT_BUBBLE;
            r_wb  <= SLOT_BUBBLE;
        end else if (i_advance) begin
            r_ex  <= i_bubble ? SLOT_BUBBLE : i_id_slot;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign o_ex  = r_ex;
    assign o_mem = r_mem;
    assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze / branch flush / load-use stall priority,
// EX operand forwarding and saturating stall/flush counters.
//   state    | meaning
//   RUN      | pipeline flowing (may still stall for load-use)
//   MEM_WAIT | MEM-stage access outstanding, whole pipeline frozen
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ID_VALID,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       ID_RD,
    input  logic             ID_REG_WRITE,
    input  logic             ID_MEM_WRITE,
    input  logic             ID_MEM_READ2,
    input  logic             EX_BR_TAKEN,
    input  logic             DMEM_READY,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_slot_t         w_id_slot;
    hz_slot_t         w_ex;
    hz_slot_t         w_mem;
    hz_slot_t         w_wb;
    hz_state_t        r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_freeze;
    logic             w_branch;
    logic             w_ld_hit;
    logic             w_load_use;
    logic             w_front_en;
    logic             w_ex_flush;
    logic             w_unused_bits;

    assign w_id_slot = '{rd:        ID_RD,
                         rs1:       ID_RS1,
                         rs2:       ID_RS2,
                         use_rs1:   ID_USES_RS1,
                         use_rs2:   ID_USES_RS2,
                         reg_write: ID_REG_WRITE,
                         load:      ID_MEM_READ2,
                         mem_op:    ID_MEM_READ2 | ID_MEM_WRITE};

    hz_shadow_pipe u_shadow (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_advance (~w_freeze),
        .i_bubble  (w_ex_flush | ~ID_VALID),
        .i_id_slot (w_id_slot),
        .o_ex      (w_ex),
        .o_mem     (w_mem),
        .o_wb      (w_wb)
    );

    // Freeze masks a taken branch; a taken branch squashes ID so load-use is moot.
    assign w_freeze   = w_mem.mem_op & ~DMEM_READY;
    assign w_branch   = EX_BR_TAKEN & ~w_freeze;
    assign w_ld_hit   = w_ex.load && (w_ex.rd != X0) && ID_VALID &&
                        ((ID_USES_RS1 && ID_RS1 == w_ex.rd) ||
                         (ID_USES_RS2 && ID_RS2 == w_ex.rd));
    assign w_load_use = w_ld_hit & ~w_freeze & ~EX_BR_TAKEN;
    assign w_front_en = ~w_freeze & ~w_load_use;
    assign w_ex_flush = w_branch | w_load_use;

    assign PC_EN       = w_front_en;
    assign IF_ID_EN    = w_front_en;
    assign ID_EX_EN    = ~w_freeze;
    assign EX_MEM_EN   = ~w_freeze;
    assign MEM_WB_EN   = ~w_freeze;
    assign IF_ID_FLUSH = w_branch;
    assign ID_EX_FLUSH = w_ex_flush;

    assign FWD_A = fwd_select(w_ex.use_rs1, w_ex.rs1, w_mem, w_wb);
    assign FWD_B = fwd_select(w_ex.use_rs2, w_ex.rs2, w_mem, w_wb);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                RUN:      if (w_freeze)  r_state <= MEM_WAIT;
                MEM_WAIT: if (DMEM_READY) r_state <= RUN;
                default:  r_state <= RUN;
            endcase
            if ((w_freeze || w_load_use) && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_branch && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign FLUSH_CNT = r_flush_cnt;

    // Several slot fields only matter in particular stages.
    assign w_unused_bits = ^{w_ex, w_mem, w_wb, r_state};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run against an in-flight instruction list model.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_reg_write, id_mem_write, id_mem_read2;
    logic          ex_br_taken, dmem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .CLK(clk), .RST_N(rst_n), .ID_VALID(id_valid),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2), .ID_RD(id_rd),
        .ID_REG_WRITE(id_reg_write), .ID_MEM_WRITE(id_mem_write),
        .ID_MEM_READ2(id_mem_read2), .EX_BR_TAKEN(ex_br_taken),
        .DMEM_READY(dmem_ready), .PC_EN(pc_en), .IF_ID_EN(if_id_en),
        .ID_EX_EN(id_ex_en), .EX_MEM_EN(ex_mem_en), .MEM_WB_EN(mem_wb_en),
        .IF_ID_FLUSH(if_id_flush), .ID_EX_FLUSH(id_ex_flush),
        .FWD_A(fwd_a), .FWD_B(fwd_b), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    // {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH}
    wire [6:0] w_ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_flush, id_ex_flush};

    // Model: in-flight instruction list, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, rw, ld, mo;
    } ins_t;

    ins_t m_pipe [3];
    int   m_stall, m_flush;
    bit   m_wait;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic bit f_freeze();
        return m_pipe[1].mo && !dmem_ready;
    endfunction

    function automatic bit f_lu();
        ins_t e = m_pipe[0];
        return e.ld && e.rd != 5'd0 && id_valid &&
               ((id_uses_rs1 && id_rs1 == e.rd) || (id_uses_rs2 && id_rs2 == e.rd));
    endfunction

    function automatic logic [6:0] f_ctrl();
        if (f_freeze())  return 7'b00000_00;
        if (ex_br_taken) return 7'b11111_11;
        if (f_lu())      return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    function automatic logic [1:0] f_fwd(input bit u, input logic [4:0] rs);
        if (!u || rs == 5'd0) return 2'b00;
        if (m_pipe[1].rw && !m_pipe[1].ld && m_pipe[1].rd == rs) return 2'b01;
        if (m_pipe[2].rw && m_pipe[2].rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_stall = 0;
        m_flush = 0;
        m_wait  = 0;
    endtask

    // Advance the model with the current inputs, then take one clock edge.
    task automatic tick();
        logic [6:0] c;
        ins_t       nid;
        bit         fz, st, fl;
        c   = f_ctrl();
        fz  = f_freeze();
        st  = fz || (!ex_br_taken && f_lu());
        fl  = !fz && ex_br_taken;
        nid = '{rd: id_rd, rs1: id_rs1, rs2: id_rs2, u1: id_uses_rs1, u2: id_uses_rs2,
                rw: id_reg_write, ld: id_mem_read2, mo: id_mem_read2 | id_mem_write};
        if (st && m_stall < CMAX) m_stall++;
        if (fl && m_flush < CMAX) m_flush++;
        if (m_wait ? dmem_ready : fz) m_wait = !m_wait;
        if (!fz) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = (c[0] || !id_valid) ? ins_t'('0) : nid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rd, input int rs1, input bit u1,
                          input int rs2, input bit u2, input bit rw, input bit mw,
                          input bit mr);
        id_valid     = v;
        id_rd        = 5'(rd);
        id_rs1       = 5'(rs1);
        id_uses_rs1  = u1;
        id_rs2       = 5'(rs2);
        id_uses_rs2  = u2;
        id_reg_write = rw;
        id_mem_write = mw;
        id_mem_read2 = mr;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        ex_br_taken = 1'b0;
        dmem_ready  = 1'b1;
        model_reset();
        #3;
        n_cmp++; if (w_ctrl !== 7'b11111_00) begin n_err++; $display("FAIL reset_ctrl: got %b expected %b", w_ctrl, 7'b11111_00); end
        n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_a, fwd_b}); end
        n_cmp++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_fwd();
        idle(); repeat (3) tick();
        set_id(1, 5, 1, 1, 2, 1, 1, 0, 0);  tick();   // add x5,x1,x2
        set_id(1, 6, 5, 1, 3, 1, 1, 0, 0);  tick();   // sub x6,x5,x3
        set_id(1, 10, 5, 1, 0, 0, 1, 0, 0); #1;       // addi x10,x5
        n_cmp++; if (fwd_a !== 2'b01) begin n_err++; $display("FAIL alu_fwd_mem: got %b expected 01", fwd_a); end
        n_cmp++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL alu_fwd_b_rf: got %b expected 00", fwd_b); end
        tick(); idle(); #1;
        n_cmp++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL alu_fwd_wb: got %b expected 10", fwd_a); end
    endtask

    task automatic test_load_use();
        int sb;
        idle(); repeat (3) tick();
        sb = m_stall;
        set_id(1, 7, 1, 1, 0, 0, 1, 0, 1); tick();    // lw x7
        set_id(1, 8, 2, 1, 7, 1, 1, 0, 0); #1;        // add x8,x2,x7
        n_cmp++; if (w_ctrl !== 7'b00111_01) begin n_err++; $display("FAIL lu_stall: got %b expected %b", w_ctrl, 7'b00111_01); end
        tick(); #1;
        n_cmp++; if (w_ctrl !== 7'b11111_00) begin n_err++; $display("FAIL lu_release: got %b expected %b", w_ctrl, 7'b11111_00); end
        tick(); idle(); #1;
        n_cmp++; if (fwd_b !== 2'b10) begin n_err++; $display("FAIL lu_fwd_wb: got %b expected 10", fwd_b); end
        n_cmp++; if (stall_cnt !== CW'(sb + 1)) begin n_err++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, sb + 1); end
    endtask

    task automatic test_x0();
        idle(); repeat (3) tick();
        set_id(1, 0, 1, 1, 0, 0, 1, 0, 1); tick();    // lw x0
        set_id(1, 9, 0, 1, 0, 1, 1, 0, 0); #1;        // add x9,x0,x0
        n_cmp++; if (w_ctrl !== 7'b11111_00) begin n_err++; $display("FAIL x0_no_stall: got %b expected %b", w_ctrl, 7'b11111_00); end
        tick();
        set_id(1, 0, 2, 1, 0, 0, 1, 0, 0); tick();    // addi x0,x2
        set_id(1, 11, 0, 1, 0, 0, 1, 0, 0); tick();   // addi x11,x0
        idle(); #1;
        n_cmp++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL x0_no_fwd: got %b expected 00", fwd_a); end
    endtask

    task automatic test_branch();
        int sb, fb;
        idle(); repeat (3) tick();
        sb = m_stall; fb = m_flush;
        set_id(1, 9, 1, 1, 0, 0, 1, 0, 1); tick();    // lw x9
        set_id(1, 12, 9, 1, 0, 0, 1, 0, 0);           // user of x9
        ex_br_taken = 1'b1; #1;
        n_cmp++; if (w_ctrl !== 7'b11111_11) begin n_err++; $display("FAIL br_over_lu: got %b expected %b", w_ctrl, 7'b11111_11); end
        tick(); ex_br_taken = 1'b0; idle(); #1;
        n_cmp++; if (flush_cnt !== CW'(fb + 1)) begin n_err++; $display("FAIL br_flush_cnt: got %0d expected %0d", flush_cnt, fb + 1); end
        n_cmp++; if (stall_cnt !== CW'(sb)) begin n_err++; $display("FAIL br_stall_cnt: got %0d expected %0d", stall_cnt, sb); end
    endtask

    task automatic test_mem_wait();
        int sb, fb;
        idle(); repeat (3) tick();
        sb = m_stall; fb = m_flush;
        set_id(1, 0, 3, 1, 4, 1, 0, 1, 0); tick();    // sw x4,0(x3)
        idle(); tick();
        dmem_ready  = 1'b0;
        ex_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (w_ctrl !== 7'b00000_00) begin n_err++; $display("FAIL wait_freeze[%0d]: got %b expected 0000000", i, w_ctrl); end
            tick();
            n_cmp++; if (dut.r_state !== MEM_WAIT) begin n_err++; $display("FAIL wait_state[%0d]: got %0d expected MEM_WAIT", i, dut.r_state); end
        end
        n_cmp++; if (stall_cnt !== CW'(sb + 3)) begin n_err++; $display("FAIL wait_stall_cnt: got %0d expected %0d", stall_cnt, sb + 3); end
        dmem_ready = 1'b1; #1;
        n_cmp++; if (w_ctrl !== 7'b11111_11) begin n_err++; $display("FAIL wait_release_br: got %b expected %b", w_ctrl, 7'b11111_11); end
        tick(); ex_br_taken = 1'b0; dmem_ready = 1'b0; #1;
        n_cmp++; if (dut.r_state !== RUN) begin n_err++; $display("FAIL wait_back_run: got %0d expected RUN", dut.r_state); end
        n_cmp++; if (w_ctrl !== 7'b11111_00) begin n_err++; $display("FAIL wait_advanced: got %b expected %b", w_ctrl, 7'b11111_00); end
        n_cmp++; if (flush_cnt !== CW'(fb + 1)) begin n_err++; $display("FAIL wait_flush_cnt: got %0d expected %0d", flush_cnt, fb + 1); end
        dmem_ready = 1'b1;
    endtask

    task automatic test_reset_and_saturate();
        idle(); dmem_ready = 1'b1; repeat (3) tick();
        set_id(1, 0, 3, 1, 4, 1, 0, 1, 0); tick();
        idle(); tick();
        dmem_ready = 1'b0; tick(); tick();
        #2; rst_n = 1'b0; #1;
        model_reset();
        n_cmp++; if (w_ctrl !== 7'b11111_00) begin n_err++; $display("FAIL rst_mid_ctrl: got %b expected %b", w_ctrl, 7'b11111_00); end
        n_cmp++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        n_cmp++; if (dut.r_state !== RUN) begin n_err++; $display("FAIL rst_mid_state: got %0d expected RUN", dut.r_state); end
        @(negedge clk); rst_n = 1'b1; dmem_ready = 1'b1;
        set_id(1, 0, 3, 1, 4, 1, 0, 1, 0); tick();
        idle(); tick();
        dmem_ready = 1'b0;
        repeat (CMAX) tick();
        n_cmp++; if (stall_cnt !== CW'(CMAX)) begin n_err++; $display("FAIL sat_reach: got %0d expected %0d", stall_cnt, CMAX); end
        repeat (4) tick();
        n_cmp++; if (stall_cnt !== CW'(CMAX)) begin n_err++; $display("FAIL sat_hold: got %0d expected %0d", stall_cnt, CMAX); end
        dmem_ready = 1'b1; tick();
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 3);
            set_id($urandom_range(0, 9) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   kind <= 1, kind == 2, kind == 1);
            ex_br_taken = ($urandom_range(0, 9) == 0);
            dmem_ready  = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++; if (w_ctrl !== f_ctrl()) begin n_err++; $display("FAIL rnd_ctrl[%0d]: got %b expected %b", i, w_ctrl, f_ctrl()); end
            n_cmp++; if (fwd_a !== f_fwd(m_pipe[0].u1, m_pipe[0].rs1)) begin n_err++; $display("FAIL rnd_fwd_a[%0d]: got %b expected %b", i, fwd_a, f_fwd(m_pipe[0].u1, m_pipe[0].rs1)); end
            n_cmp++; if (fwd_b !== f_fwd(m_pipe[0].u2, m_pipe[0].rs2)) begin n_err++; $display("FAIL rnd_fwd_b[%0d]: got %b expected %b", i, fwd_b, f_fwd(m_pipe[0].u2, m_pipe[0].rs2)); end
            n_cmp++; if (stall_cnt !== CW'(m_stall)) begin n_err++; $display("FAIL rnd_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, m_stall); end
            n_cmp++; if (flush_cnt !== CW'(m_flush)) begin n_err++; $display("FAIL rnd_flush_cnt[%0d]: got %0d expected %0d", i, flush_cnt, m_flush); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_x0();
        test_branch();
        test_mem_wait();
        test_reset_and_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It tracks destination and source registers of in-flight instructions in a shadow pipeline, and generates the datapath control that keeps the pipeline correct:
- pipeline enables and flushes,
- EX-stage operand forwarding selects,
- load-use stalls and data-memory wait freezes.

It sits beside the decoder in ID and consumes the decoder's REG_WRITE / MEM_WRITE / MEM_READ2 outputs.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters.

Ports:
- Clocking (already decided): one clock; reset is asynchronous and active-low.
- CLK  in  1  core clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ID_VALID  in  1  ID stage holds a real instruction.
- ID_RS1, ID_RS2  in  5 each  source register indices of the ID instruction.
- ID_USES_RS1, ID_USES_RS2  in  1 each  ID instruction reads that source.
- ID_RD  in  5  destination index of the ID instruction.
- ID_REG_WRITE, ID_MEM_WRITE, ID_MEM_READ2  in  1 each  decoder controls for the ID instruction.
- EX_BR_TAKEN  in  1  branch/JAL/JALR resolved taken in EX this cycle.
- DMEM_READY  in  1  data memory completes the MEM-stage access this cycle.
- PC_EN  out  1  PC register load enable.
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1 each  pipeline register enables.
- IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  load a bubble (NOP, all controls 0) into that register.
- FWD_A, FWD_B  out  2 each  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- STALL_CNT, FLUSH_CNT  out  CNT_W each  saturating count of stall cycles and of flush events.

## Operation
Shadow pipeline:
- Three slots: EX, MEM, WB. Each slot holds rd, rs1, rs2, use bits, reg_write, load and mem_op (load or store).
- A bubble slot has every field 0.
- On an unfrozen clock edge, the slots advance:
  - EX takes the ID fields, or a bubble when ID_EX_FLUSH is 1 or ID_VALID is 0.
  - MEM takes EX.
  - WB takes MEM.
- On a frozen edge, all slots hold.

Hazard priority, highest first:
1. Freeze:
   - Condition: MEM slot mem_op=1 and DMEM_READY=0.
   - Outputs: PC_EN, all stage enables = 0; no flushes.
   - EX_BR_TAKEN is ignored while frozen; the branch stays in EX and is honoured once the freeze lifts.
2. Taken branch:
   - Condition: EX_BR_TAKEN=1.
   - Outputs: IF_ID_FLUSH=1, ID_EX_FLUSH=1, all enables 1.
   - A load-use hazard detected in the same cycle is discarded; the ID instruction is squashed anyway.
3. Load-use:
   - Condition: EX slot load=1, EX rd≠0, ID_VALID=1, and (ID_USES_RS1 with ID_RS1==EX rd, or ID_USES_RS2 with ID_RS2==EX rd).
   - Outputs: PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1; remaining enables 1.
4. Otherwise: all enables 1, no flushes.

Forwarding for the EX slot, evaluated independently per operand:
- Select 01 if MEM reg_write=1, MEM rd≠0, MEM load=0, and MEM rd matches.
- Otherwise select 10 if WB reg_write=1, WB rd≠0, and WB rd matches.
- Otherwise select 00.
- MEM has priority over WB.
- x0 is never forwarded.
- An operand whose use bit is 0 always selects 00.

FSM, with states RUN and MEM_WAIT:
- RUN → MEM_WAIT when the freeze condition holds.
- MEM_WAIT → RUN on the cycle DMEM_READY=1. That cycle is unfrozen and the pipeline advances.

Counters (both saturate at all-ones; no wrap):
- STALL_CNT increments once per cycle in which a freeze or a load-use stall is active.
- FLUSH_CNT increments once per taken-branch flush cycle.

## Timing
Combinational paths:
- All control outputs and FWD_A/FWD_B are combinational, from the shadow slots, the ID inputs, EX_BR_TAKEN and DMEM_READY.
- Latency from these inputs to the outputs is zero cycles.

Load-use stall:
- Inserts exactly one bubble.
- On the next cycle the load has moved to MEM, where forwarding is blocked for loads. That cycle the load's rd matches nothing in the load-use check, so ID proceeds.
- The consumer then enters EX and picks up the loaded value via WB forwarding (select 10).

Reset (RST_N=0, asynchronous):
- All slots become bubbles, state becomes RUN, counters become 0.
- Resulting outputs: PC_EN=1, all stage enables = 1, flushes = 0, FWD_A = FWD_B = 00, STALL_CNT = FLUSH_CNT = 0.
- Reset asserted mid-stall or mid-wait overrides everything immediately.

Release:
- Deassertion is sampled synchronously by the surrounding reset synchronizer.
- The first post-reset edge advances normally.

## Structure
- The shared package pipeline_pkg holds:
  - fwd_sel_t with FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - hz_state_t with RUN and MEM_WAIT;
  - the slot struct hz_slot_t;
  - the constant X0=5'd0.
- One sub-module, hz_shadow_pipe: the three-slot register chain with advance/hold/bubble inputs.
- Hazard priority, forwarding, FSM and counters live in hazard_ctrl.

## Test plan
- Back-to-back ALU dependency (add x5; then sub using rs1=x5) → FWD_A=01 in sub's EX cycle. One instruction later, a user of x5 → FWD_A=10.
- Load x7, then add with rs2=x7 → one cycle with PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1; then FWD_B=10; STALL_CNT=1.
- Write to x0, then a read of x0 → FWD_A=00 and no stall, even for a load to x0.
- EX_BR_TAKEN=1 together with a load-use hazard → IF_ID_FLUSH=ID_EX_FLUSH=1, PC_EN=1; FLUSH_CNT=1, STALL_CNT unchanged.
- Store in MEM with DMEM_READY low for 3 cycles → all enables 0 for 3 cycles, state MEM_WAIT, STALL_CNT=3. On the 4th cycle (ready=1) the pipeline advances and state returns to RUN.
- Reset pulse during MEM_WAIT → outputs at reset values immediately; counters 0; force STALL_CNT to all-ones and apply a further stall → value holds (saturation).
